// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the MIPS control/execute slice: opcodes, funct codes,
// ALUOp classes and 3-bit ALU control codes.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_SUB    = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
    localparam logic [1:0] ALUOP_SLT    = 2'b11;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

endpackage

// File: rtl/mips_ctrl_exec_alu_decoder.sv
// ALU-control decoder: maps the ALUOp class and R-type funct field to a
// 3-bit ALU operation code.
module alu_decoder
    import mips_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_ctrl
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_ctrl = ALU_ADD;
            ALUOP_SUB: alu_ctrl = ALU_SUB;
            ALUOP_SLT: alu_ctrl = ALU_SLT;
            default: begin
                case (funct)
                    FN_ADD:  alu_ctrl = ALU_ADD;
                    FN_SUB:  alu_ctrl = ALU_SUB;
                    FN_AND:  alu_ctrl = ALU_AND;
                    FN_OR:   alu_ctrl = ALU_OR;
                    FN_SLT:  alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mips_ctrl_exec.sv
// Control-and-execute slice: combinational main/ALU decode in ID plus a
// registered 32-bit ALU for EX/MEM. Define SLTI_EN to add slti decode.
module mips_ctrl_exec
    import mips_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [5:0]            opcode,
    input  logic [5:0]            funct,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic [2:0]            ex_alu_ctrl,
    output logic                  reg_dst,
    output logic                  branch,
    output logic                  branch_n,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic                  mem_to_reg,
    output logic                  jump,
    output logic                  alu_src,
    output logic                  reg_write,
    output logic [1:0]            alu_op,
    output logic [2:0]            alu_ctrl,
    output logic                  noop,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero
);

    logic [DATA_WIDTH-1:0] alu_next;

    // Reset forces a bubble into ID regardless of the fetched opcode.
    always_comb begin
        reg_dst    = 1'b0;
        branch     = 1'b0;
        branch_n   = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_to_reg = 1'b0;
        jump       = 1'b0;
        alu_src    = 1'b0;
        reg_write  = 1'b0;
        alu_op     = ALUOP_ADD;
        noop       = 1'b1;
        if (rst) begin
            noop = 1'b0;
            case (opcode)
                OP_RTYPE: begin
                    reg_dst   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = ALUOP_FUNCT;
                end
                OP_LW: begin
                    alu_src    = 1'b1;
                    mem_read   = 1'b1;
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                end
                OP_SW: begin
                    alu_src   = 1'b1;
                    mem_write = 1'b1;
                end
                OP_ADDI: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                end
                OP_BEQ: begin
                    branch = 1'b1;
                    alu_op = ALUOP_SUB;
                end
                OP_BNE: begin
                    branch_n = 1'b1;
                    alu_op   = ALUOP_SUB;
                end
                OP_J: jump = 1'b1;
`ifdef SLTI_EN
                OP_SLTI: begin
                    alu_src   = 1'b1;
                    reg_write = 1'b1;
                    alu_op    = ALUOP_SLT;
                end
`endif
                default: noop = 1'b1;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .alu_op   (alu_op),
        .funct    (funct),
        .alu_ctrl (alu_ctrl)
    );

    always_comb begin
        alu_next = '0;
        case (ex_alu_ctrl)
            ALU_AND: alu_next = a & b;
            ALU_OR:  alu_next = a | b;
            ALU_ADD: alu_next = a + b;
            ALU_SUB: alu_next = a - b;
            ALU_SLT: alu_next = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result <= '0;
            zero   <= 1'b1;
        end else begin
            result <= alu_next;
            zero   <= (alu_next == '0);
        end
    end

endmodule

// File: tb/tb_mips_ctrl_exec.sv
// Directed-vector bench for mips_ctrl_exec: decode sweep, ALU ops, reset
// behaviour. Compile with +define+SLTI_EN to exercise slti decode.
module tb_mips_ctrl_exec;

    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  ex_alu_ctrl;
    logic        reg_dst, branch, branch_n, mem_read, mem_write;
    logic        mem_to_reg, jump, alu_src, reg_write, noop, zero;
    logic [1:0]  alu_op;
    logic [2:0]  alu_ctrl;
    logic [31:0] result;

    int vec_cnt  = 0;
    int miss_cnt = 0;

    mips_ctrl_exec #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .funct       (funct),
        .a           (a),
        .b           (b),
        .ex_alu_ctrl (ex_alu_ctrl),
        .reg_dst     (reg_dst),
        .branch      (branch),
        .branch_n    (branch_n),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_to_reg  (mem_to_reg),
        .jump        (jump),
        .alu_src     (alu_src),
        .reg_write   (reg_write),
        .alu_op      (alu_op),
        .alu_ctrl    (alu_ctrl),
        .noop        (noop),
        .result      (result),
        .zero        (zero)
    );

    always #5 clk = ~clk;

    // {reg_dst,branch,branch_n,mem_read,mem_write,mem_to_reg,jump,alu_src,reg_write}
    logic [8:0] ctl;
    assign ctl = {reg_dst, branch, branch_n, mem_read, mem_write,
                  mem_to_reg, jump, alu_src, reg_write};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic dec(input string tag, input logic [5:0] op, input logic [5:0] fn,
                       input logic [8:0] exp_ctl, input logic [1:0] exp_op,
                       input logic [2:0] exp_alu, input logic exp_noop);
        opcode = op;
        funct  = fn;
        #1;
        check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        check({tag, "_aluop"}, 32'(alu_op), 32'(exp_op));
        check({tag, "_aluctrl"}, 32'(alu_ctrl), 32'(exp_alu));
        check({tag, "_noop"}, 32'(noop), 32'(exp_noop));
    endtask

    task automatic alu(input string tag, input logic [2:0] code, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp_res, input logic exp_zero);
        @(negedge clk);
        ex_alu_ctrl = code;
        a = va;
        b = vb;
        @(posedge clk);
        #1;
        check({tag, "_res"}, result, exp_res);
        check({tag, "_zero"}, 32'(zero), 32'(exp_zero));
    endtask

    initial begin
        rst = 1'b0;
        opcode = 6'b100011;
        funct = 6'b000000;
        a = 32'd3;
        b = 32'd4;
        ex_alu_ctrl = 3'b010;
        #2;
        dec("rst_lw", 6'b100011, 6'b000000, 9'b000000000, 2'b00, 3'b010, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        check("rst_res", result, 32'h0);
        check("rst_zero", 32'(zero), 32'h1);

        @(negedge clk);
        rst = 1'b1;
        dec("lw", 6'b100011, 6'b000000, 9'b000101011, 2'b00, 3'b010, 1'b0);
        check("rel_hold_res", result, 32'h0);
        @(posedge clk);
        #1;
        check("rel_first_res", result, 32'd7);

        dec("rsub", 6'b000000, 6'b100010, 9'b100000001, 2'b10, 3'b110, 1'b0);
        dec("radd", 6'b000000, 6'b100000, 9'b100000001, 2'b10, 3'b010, 1'b0);
        dec("rand", 6'b000000, 6'b100100, 9'b100000001, 2'b10, 3'b000, 1'b0);
        dec("ror",  6'b000000, 6'b100101, 9'b100000001, 2'b10, 3'b001, 1'b0);
        dec("rslt", 6'b000000, 6'b101010, 9'b100000001, 2'b10, 3'b111, 1'b0);
        dec("rxx",  6'b000000, 6'b000111, 9'b100000001, 2'b10, 3'b010, 1'b0);
        dec("sw",   6'b101011, 6'b100010, 9'b000010010, 2'b00, 3'b010, 1'b0);
        dec("addi", 6'b001000, 6'b100010, 9'b000000011, 2'b00, 3'b010, 1'b0);
        dec("beq",  6'b000100, 6'b100100, 9'b010000000, 2'b01, 3'b110, 1'b0);
        dec("bne",  6'b000101, 6'b000000, 9'b001000000, 2'b01, 3'b110, 1'b0);
        dec("j",    6'b000010, 6'b100010, 9'b000000100, 2'b00, 3'b010, 1'b0);
        dec("bad",  6'b111111, 6'b100010, 9'b000000000, 2'b00, 3'b010, 1'b1);
`ifdef SLTI_EN
        dec("slti", 6'b001010, 6'b000000, 9'b000000011, 2'b11, 3'b111, 1'b0);
`else
        dec("slti", 6'b001010, 6'b000000, 9'b000000000, 2'b00, 3'b010, 1'b1);
`endif

        alu("add",     3'b010, 32'd5, 32'd7, 32'd12, 1'b0);
        alu("sub_eq",  3'b110, 32'd9, 32'd9, 32'd0, 1'b1);
        alu("slt_neg", 3'b111, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0);
        alu("slt_pos", 3'b111, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1);
        alu("slt_min", 3'b111, 32'h80000000, 32'd0, 32'd1, 1'b0);
        alu("code011", 3'b011, 32'hFFFF, 32'h1, 32'd0, 1'b1);
        alu("code100", 3'b100, 32'h1234, 32'h1, 32'd0, 1'b1);
        alu("and",     3'b000, 32'h0000F0F0, 32'h00000FF0, 32'h000000F0, 1'b0);
        alu("or",      3'b001, 32'h0000F0F0, 32'h00000FF0, 32'h0000FFF0, 1'b0);
        alu("add_wrap",3'b010, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b1);
        alu("sub_wrap",3'b110, 32'h80000000, 32'd1, 32'h7FFFFFFF, 1'b0);
        alu("sub_neg", 3'b110, 32'd3, 32'd5, 32'hFFFFFFFE, 1'b0);

        // Asynchronous reset mid-cycle must clear without a clock edge.
        @(negedge clk);
        a = 32'd100;
        b = 32'd23;
        ex_alu_ctrl = 3'b010;
        #2;
        rst = 1'b0;
        #1;
        check("arst_res", result, 32'h0);
        check("arst_zero", 32'(zero), 32'h1);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold", result, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_rel_pre", result, 32'h0);
        @(posedge clk);
        #1;
        check("arst_rel_post", result, 32'd123);
        check("arst_rel_zero", 32'(zero), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
